// File: rtl/alu_arb_if.sv
// Shared ALU-unit types and the requester/response/AFU bundle of the two-port ALU arbiter.
// The master side is the requesters plus the AFU; the slave side is the arbiter.
package alu_arb_pkg;
    typedef enum logic [1:0] {
        AM_RS1 = 2'd0,
        AM_RS2 = 2'd1,
        AM_IMM = 2'd2,
        AM_PC  = 2'd3
    } ALU_SEL_TYPE;

    typedef enum logic [3:0] {
        A_ADD  = 4'd0,
        A_SUB  = 4'd1,
        A_AND  = 4'd2,
        A_OR   = 4'd3,
        A_XOR  = 4'd4,
        A_SLT  = 4'd5,
        A_SLTU = 4'd6,
        A_SLL  = 4'd7,
        A_SRL  = 4'd8,
        A_SRA  = 4'd9
    } ALU_OP_TYPE;
endpackage

interface alu_arb_if #(
    parameter int RSZ   = 32,
    parameter int PC_SZ = 32
);
    import alu_arb_pkg::*;

    logic        [1:0]            req_valid;
    logic        [1:0]            req_ready;
    logic        [1:0][RSZ-1:0]   req_rs1;
    logic        [1:0][RSZ-1:0]   req_rs2;
    logic        [1:0][RSZ-1:0]   req_imm;
    logic        [1:0][PC_SZ-1:0] req_pc;
    ALU_SEL_TYPE [1:0]            req_sel_x;
    ALU_SEL_TYPE [1:0]            req_sel_y;
    ALU_OP_TYPE  [1:0]            req_op;

    logic        [1:0]            rsp_valid;
    logic        [1:0]            rsp_ready;
    logic        [1:0][RSZ-1:0]   rsp_data;

    logic        [RSZ-1:0]        afu_Rs1_data;
    logic        [RSZ-1:0]        afu_Rs2_data;
    logic        [RSZ-1:0]        afu_imm;
    logic        [PC_SZ-1:0]      afu_pc;
    ALU_SEL_TYPE                  afu_sel_x;
    ALU_SEL_TYPE                  afu_sel_y;
    ALU_OP_TYPE                   afu_op;
    logic        [RSZ-1:0]        afu_Rd_data;

    modport master (
        output req_valid, req_rs1, req_rs2, req_imm, req_pc, req_sel_x, req_sel_y, req_op,
        output rsp_ready, afu_Rd_data,
        input  req_ready, rsp_valid, rsp_data,
        input  afu_Rs1_data, afu_Rs2_data, afu_imm, afu_pc, afu_sel_x, afu_sel_y, afu_op
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_imm, req_pc, req_sel_x, req_sel_y, req_op,
        input  rsp_ready, afu_Rd_data,
        output req_ready, rsp_valid, rsp_data,
        output afu_Rs1_data, afu_Rs2_data, afu_imm, afu_pc, afu_sel_x, afu_sel_y, afu_op
    );
endinterface

// File: rtl/alu_arb.sv
// Round-robin sharing of one combinational ALU unit between two requesters,
// with a one-deep registered result buffer per requester (1-cycle latency).
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int RSZ   = 32,
    parameter int PC_SZ = 32
) (
    input  logic     clk_in,
    input  logic     reset_in,
    alu_arb_if.slave bus
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t [1:0]          state_r;
    buf_state_t [1:0]          state_next_s;
    logic       [1:0]          rsp_valid_s;
    logic       [1:0]          elig_s;
    logic       [1:0]          grant_s;
    logic                      grant_any_s;
    logic                      grant_idx_s;
    logic                      last_grant_r;
    logic       [1:0][RSZ-1:0] rsp_data_r;

    // Eligibility and round-robin choice; a buffer draining this cycle may be refilled.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_valid_s[i] = (state_r[i] == BUF_FULL);
        end
        elig_s  = bus.req_valid & (~rsp_valid_s | bus.rsp_ready);
        grant_s = 2'b00;
        if (reset_in) begin
            grant_s = 2'b00;
        end else begin
            case (elig_s)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end
        grant_any_s = |grant_s;
        grant_idx_s = grant_s[1];
    end

    // AFU operand mux: granted port's fields, otherwise a quiet ADD of zeros.
    always_comb begin
        bus.afu_Rs1_data = grant_any_s ? bus.req_rs1[grant_idx_s]   : {RSZ{1'b0}};
        bus.afu_Rs2_data = grant_any_s ? bus.req_rs2[grant_idx_s]   : {RSZ{1'b0}};
        bus.afu_imm      = grant_any_s ? bus.req_imm[grant_idx_s]   : {RSZ{1'b0}};
        bus.afu_pc       = grant_any_s ? bus.req_pc[grant_idx_s]    : {PC_SZ{1'b0}};
        bus.afu_sel_x    = grant_any_s ? bus.req_sel_x[grant_idx_s] : AM_RS1;
        bus.afu_sel_y    = grant_any_s ? bus.req_sel_y[grant_idx_s] : AM_RS1;
        bus.afu_op       = grant_any_s ? bus.req_op[grant_idx_s]    : A_ADD;
    end

    // Per-port buffer next state: a grant always (re)fills, a consume without grant empties.
    always_comb begin
        state_next_s = state_r;
        for (int i = 0; i < 2; i++) begin
            case (state_r[i])
                BUF_EMPTY: state_next_s[i] = grant_s[i] ? BUF_FULL : BUF_EMPTY;
                BUF_FULL:  state_next_s[i] = (grant_s[i] || !bus.rsp_ready[i]) ? BUF_FULL : BUF_EMPTY;
                default:   state_next_s[i] = BUF_EMPTY;
            endcase
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r <= {BUF_EMPTY, BUF_EMPTY};
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result capture and round-robin pointer; last_grant=1 lets port 0 win first.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rsp_data_r   <= {2{{RSZ{1'b0}}}};
            last_grant_r <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant_s[i]) begin
                    rsp_data_r[i] <= bus.afu_Rd_data;
                end else begin
                    rsp_data_r[i] <= rsp_data_r[i];
                end
            end
            if (grant_any_s) begin
                last_grant_r <= grant_idx_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_data  = rsp_data_r;

endmodule
